// File: rtl/stuff_scramble_pkg.sv
// -----------------------------------------------------------------------------
// stuff_scramble_pkg
// Shared DisplayPort symbol constants, scrambler seed and training-pattern
// helpers for the stuff_scramble block.
//   symBS / symSR / symBE : framing K codes (K28.5, K28.0, K27.7)
//   symK28_5, symD10_2, symD11_6 : training pattern symbols
//   train_e               : encoding of the train port
//   tps2_pair()           : symbol pair for one clock of the TPS2 period
// -----------------------------------------------------------------------------
package stuff_scramble_pkg;

  localparam logic [7:0] symBS     = 8'hBC;  // K28.5
  localparam logic [7:0] symSR     = 8'h1C;  // K28.0
  localparam logic [7:0] symBE     = 8'hFB;  // K27.7
  localparam logic [7:0] symK28_5  = 8'hBC;
  localparam logic [7:0] symD10_2  = 8'h4A;
  localparam logic [7:0] symD11_6  = 8'hCB;

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  // TPS2 repeats every 5 clocks (10 symbols, two per clock).
  localparam logic [2:0] TPS2_LAST = 3'd4;

  typedef enum logic [1:0] {
    TRAIN_NORMAL     = 2'd0,
    TRAIN_TPS1       = 2'd1,
    TRAIN_TPS2       = 2'd2,
    TRAIN_NORMAL_ALT = 2'd3
  } train_e;

  typedef struct packed {
    logic [1:0]  isk;
    logic [15:0] dat;
  } sym_pair_t;

  // Clocks 0 and 1 carry K28.5 (low) + D11.6 (high); clocks 2..4 carry D10.2.
  function automatic sym_pair_t tps2_pair(input logic [2:0] ptr);
    sym_pair_t p;
    if (ptr < 3'd2) begin
      p.dat = {symD11_6, symK28_5};
      p.isk = 2'b01;
    end else begin
      p.dat = {symD10_2, symD10_2};
      p.isk = 2'b00;
    end
    return p;
  endfunction

endpackage

// File: rtl/stuff_scramble_scrstep.sv
// -----------------------------------------------------------------------------
// stuff_scramble_scrstep
// One symbol step of the DisplayPort scrambler, G(X)=X^16+X^5+X^4+X^3+1.
// Purely combinational: advances the LFSR 8 bits and XORs the keystream onto
// a data symbol (bit 0 first); K symbols pass through unchanged while the
// LFSR still advances.
//   i_lfsr : current LFSR state
//   i_dat  : input symbol
//   i_isk  : 1 = K symbol (not scrambled)
//   o_dat  : output symbol
//   o_lfsr : LFSR state after 8 steps
// -----------------------------------------------------------------------------
module stuff_scramble_scrstep (
  input  logic [15:0] i_lfsr,
  input  logic [7:0]  i_dat,
  input  logic        i_isk,
  output logic [7:0]  o_dat,
  output logic [15:0] o_lfsr
);

  logic [15:0] w_lfsr;
  logic [7:0]  w_ks;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    w_lfsr = i_lfsr;
    w_ks   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      // Output tap is bit 15; it is fed back into bit 0 and bits 3..5.
      w_ks[i] = w_lfsr[15];
      w_lfsr  = {w_lfsr[14:0], w_lfsr[15]} ^ {10'b0, {3{w_lfsr[15]}}, 3'b000};
    end
  end

  assign o_dat  = i_isk ? i_dat : (i_dat ^ w_ks);
  assign o_lfsr = w_lfsr;

endmodule

// File: rtl/stuff_scramble.sv
// -----------------------------------------------------------------------------
// stuff_scramble
// DisplayPort scrambler stage between the stuffing stage and the 8b10b
// encoder. Two symbols per lane per clock (low byte first), one clock latency.
// Every SRPERIOD-th BS on lane 0 is replaced by SR on all active lanes and the
// LFSR is reseeded right after it.
// Optional feature: define SCRAMBLE_TRAINING_EN to generate TPS1/TPS2 training
// patterns from the train port; otherwise train is ignored.
//   dpclk            : clock
//   reset            : synchronous, active-high
//   dpdat0/1, dpisk0/1 : lane 0/1 symbol pair and per-byte K flags
//   twolane          : 1 = lane 1 active
//   train            : 0/3 normal, 1 TPS1, 2 TPS2
//   scrdat0/1, scrisk0/1 : registered scrambled output and K flags
// -----------------------------------------------------------------------------
module stuff_scramble
  import stuff_scramble_pkg::*;
#(
  parameter int SRPERIOD = 512
) (
  input  logic        dpclk,
  input  logic        reset,
  input  logic [15:0] dpdat0,
  input  logic [15:0] dpdat1,
  input  logic [1:0]  dpisk0,
  input  logic [1:0]  dpisk1,
  input  logic        twolane,
  input  logic [1:0]  train,
  output logic [15:0] scrdat0,
  output logic [15:0] scrdat1,
  output logic [1:0]  scrisk0,
  output logic [1:0]  scrisk1
);

  localparam logic [8:0] BS_LAST = 9'(SRPERIOD - 1);

  logic [15:0] r_lfsr;
  logic [8:0]  r_bscnt;
  logic [15:0] r_scrdat0, r_scrdat1;
  logic [1:0]  r_scrisk0, r_scrisk1;

  logic [8:0]  w_cnt_start, w_cnt_mid, w_cnt_end;
  logic        w_sr_lo, w_sr_hi;
  logic [15:0] w_lfsr_mid_step, w_lfsr_end_step;
  logic [15:0] w_lfsr_mid, w_lfsr_end;
  logic [7:0]  w_lo0, w_hi0, w_lo1, w_hi1;
  logic [15:0] w_unused_lfsr_lo1, w_unused_lfsr_hi1;
  logic [15:0] w_dat0, w_dat1;
  logic [1:0]  w_isk0, w_isk1;
  logic [15:0] w_lfsr_nxt;
  logic [8:0]  w_bscnt_nxt;

`ifdef SCRAMBLE_TRAINING_EN
  logic [1:0]  r_prev_train;
  logic [2:0]  r_tps_ptr;
  logic [2:0]  w_tps_ptr;
  train_e      w_mode;
  sym_pair_t   w_tps2;

  assign w_mode    = train_e'(train);
  // Any change of train restarts the TPS2 period at its first symbol.
  assign w_tps_ptr = (train != r_prev_train) ? 3'd0 : r_tps_ptr;
  assign w_tps2    = tps2_pair(w_tps_ptr);
  // Leaving training forces the next BS to go out as SR.
  assign w_cnt_start = (r_prev_train != 2'd0 && train == 2'd0) ? BS_LAST : r_bscnt;
`else
  logic w_unused_train;
  assign w_unused_train = ^train;
  assign w_cnt_start    = r_bscnt;
`endif

  // Lane 0 chain: low byte step feeds the high byte step.
  stuff_scramble_scrstep u_step_lo0 (
    .i_lfsr (r_lfsr),
    .i_dat  (dpdat0[7:0]),
    .i_isk  (dpisk0[0]),
    .o_dat  (w_lo0),
    .o_lfsr (w_lfsr_mid_step)
  );

  stuff_scramble_scrstep u_step_hi0 (
    .i_lfsr (w_lfsr_mid),
    .i_dat  (dpdat0[15:8]),
    .i_isk  (dpisk0[1]),
    .o_dat  (w_hi0),
    .o_lfsr (w_lfsr_end_step)
  );

  // Lane 1 shares lane 0's LFSR state at each symbol position.
  stuff_scramble_scrstep u_step_lo1 (
    .i_lfsr (r_lfsr),
    .i_dat  (dpdat1[7:0]),
    .i_isk  (dpisk1[0]),
    .o_dat  (w_lo1),
    .o_lfsr (w_unused_lfsr_lo1)
  );

  stuff_scramble_scrstep u_step_hi1 (
    .i_lfsr (w_lfsr_mid),
    .i_dat  (dpdat1[15:8]),
    .i_isk  (dpisk1[1]),
    .o_dat  (w_hi1),
    .o_lfsr (w_unused_lfsr_hi1)
  );

  // BS counting in byte order; a second BS in the same cycle sees the count
  // already updated by the first.
  always_comb begin
    w_sr_lo   = 1'b0;
    w_cnt_mid = w_cnt_start;
    if (dpisk0[0] && dpdat0[7:0] == symBS) begin
      if (w_cnt_start == BS_LAST) begin
        w_sr_lo   = 1'b1;
        w_cnt_mid = 9'd0;
      end else begin
        w_cnt_mid = w_cnt_start + 9'd1;
      end
    end

    w_sr_hi   = 1'b0;
    w_cnt_end = w_cnt_mid;
    if (dpisk0[1] && dpdat0[15:8] == symBS) begin
      if (w_cnt_mid == BS_LAST) begin
        w_sr_hi   = 1'b1;
        w_cnt_end = 9'd0;
      end else begin
        w_cnt_end = w_cnt_mid + 9'd1;
      end
    end
  end

  // Symbol after an SR always starts from the seed.
  assign w_lfsr_mid = w_sr_lo ? LFSR_SEED : w_lfsr_mid_step;
  assign w_lfsr_end = w_sr_hi ? LFSR_SEED : w_lfsr_end_step;

  always_comb begin
    w_dat0      = {(w_sr_hi ? symSR : w_hi0), (w_sr_lo ? symSR : w_lo0)};
    w_isk0      = {dpisk0[1] | w_sr_hi, dpisk0[0] | w_sr_lo};
    w_dat1      = {(w_sr_hi ? symSR : w_hi1), (w_sr_lo ? symSR : w_lo1)};
    w_isk1      = {dpisk1[1] | w_sr_hi, dpisk1[0] | w_sr_lo};
    w_lfsr_nxt  = w_lfsr_end;
    w_bscnt_nxt = w_cnt_end;
`ifdef SCRAMBLE_TRAINING_EN
    // Training patterns go out unscrambled with scrambler state frozen.
    case (w_mode)
      TRAIN_TPS1: begin
        w_dat0      = {symD10_2, symD10_2};
        w_isk0      = 2'b00;
        w_dat1      = {symD10_2, symD10_2};
        w_isk1      = 2'b00;
        w_lfsr_nxt  = r_lfsr;
        w_bscnt_nxt = r_bscnt;
      end
      TRAIN_TPS2: begin
        w_dat0      = w_tps2.dat;
        w_isk0      = w_tps2.isk;
        w_dat1      = w_tps2.dat;
        w_isk1      = w_tps2.isk;
        w_lfsr_nxt  = r_lfsr;
        w_bscnt_nxt = r_bscnt;
      end
      default: ;
    endcase
`endif
    if (!twolane) begin
      w_dat1 = 16'h0000;
      w_isk1 = 2'b00;
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge dpclk) begin
    if (reset) begin
      r_lfsr    <= LFSR_SEED;
      r_bscnt   <= BS_LAST;
      r_scrdat0 <= '0;
      r_scrdat1 <= '0;
      r_scrisk0 <= '0;
      r_scrisk1 <= '0;
    end else begin
      r_lfsr    <= w_lfsr_nxt;
      r_bscnt   <= w_bscnt_nxt;
      r_scrdat0 <= w_dat0;
      r_scrdat1 <= w_dat1;
      r_scrisk0 <= w_isk0;
      r_scrisk1 <= w_isk1;
    end
  end

`ifdef SCRAMBLE_TRAINING_EN
  always_ff @(posedge dpclk) begin
    if (reset) begin
      r_prev_train <= 2'd0;
      r_tps_ptr    <= 3'd0;
    end else begin
      r_prev_train <= train;
      r_tps_ptr    <= (w_tps_ptr == TPS2_LAST) ? 3'd0 : w_tps_ptr + 3'd1;
    end
  end
`endif

  assign scrdat0 = r_scrdat0;
  assign scrdat1 = r_scrdat1;
  assign scrisk0 = r_scrisk0;
  assign scrisk1 = r_scrisk1;

endmodule

// File: tb/tb_stuff_scramble.sv
// -----------------------------------------------------------------------------
// tb_stuff_scramble
// Scoreboard bench for stuff_scramble: a behavioural model pushes the expected
// output of each driven cycle, which is popped and compared one clock later.
// Directed checks cover the known zero-data keystream, SR placement and the
// training patterns (when SCRAMBLE_TRAINING_EN is defined).
// -----------------------------------------------------------------------------
module tb_stuff_scramble;

  localparam int          SRP  = 512;
  localparam logic [15:0] SEED = 16'hFFFF;
  localparam logic [7:0]  BS   = 8'hBC;
  localparam logic [7:0]  SR   = 8'h1C;

  logic        dpclk   = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] dpdat0  = '0;
  logic [15:0] dpdat1  = '0;
  logic [1:0]  dpisk0  = '0;
  logic [1:0]  dpisk1  = '0;
  logic        twolane = 1'b1;
  logic [1:0]  train   = '0;
  logic [15:0] scrdat0, scrdat1;
  logic [1:0]  scrisk0, scrisk1;

  stuff_scramble #(.SRPERIOD(SRP)) dut (
    .dpclk   (dpclk),
    .reset   (reset),
    .dpdat0  (dpdat0),
    .dpdat1  (dpdat1),
    .dpisk0  (dpisk0),
    .dpisk1  (dpisk1),
    .twolane (twolane),
    .train   (train),
    .scrdat0 (scrdat0),
    .scrdat1 (scrdat1),
    .scrisk0 (scrisk0),
    .scrisk1 (scrisk1)
  );

  always #5 dpclk = ~dpclk;

  typedef struct {
    logic [15:0] d0, d1;
    logic [1:0]  k0, k1;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [15:0] m_lfsr  = SEED;
  logic [8:0]  m_bscnt = 9'(SRP - 1);
  logic [1:0]  m_prev  = 2'd0;
  int          m_ptr   = 0;

  // Last sampled DUT outputs
  logic [15:0] o_d0, o_d1;
  logic [1:0]  o_k0, o_k1;

  logic [7:0] zseq [0:7] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};
  logic [7:0] zq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Serial keystream generator: 8 output bits, bit 0 first.
  task automatic ks_next(output logic [7:0] ks);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b      = m_lfsr[15];
      ks[i]  = b;
      m_lfsr = {m_lfsr[14:0], b} ^ (b ? 16'h0038 : 16'h0000);
    end
  endtask

  task automatic model_push();
    exp_t e;
    logic [7:0] x0, x1, ks;
    logic sr;
    int p;
    e = '{default: '0};
    if (reset) begin
      m_lfsr  = SEED;
      m_bscnt = 9'(SRP - 1);
      m_prev  = 2'd0;
      m_ptr   = 0;
      sb.push_back(e);
      return;
    end
`ifdef SCRAMBLE_TRAINING_EN
    p     = (train != m_prev) ? 0 : m_ptr;
    m_ptr = (p + 1) % 5;
    if (m_prev != 2'd0 && train == 2'd0) m_bscnt = 9'(SRP - 1);
    m_prev = train;
    if (train == 2'd1 || train == 2'd2) begin
      if (train == 2'd1 || p >= 2) begin
        e.d0 = 16'h4A4A; e.k0 = 2'b00;
      end else begin
        e.d0 = 16'hCBBC; e.k0 = 2'b01;
      end
      if (twolane) begin
        e.d1 = e.d0; e.k1 = e.k0;
      end
      sb.push_back(e);
      return;
    end
`else
    p = 0;
`endif
    for (int b = 0; b < 2; b++) begin
      x0 = dpdat0[8*b +: 8];
      x1 = dpdat1[8*b +: 8];
      sr = 1'b0;
      if (dpisk0[b] && x0 == BS) begin
        if (m_bscnt == 9'(SRP - 1)) begin
          sr = 1'b1; m_bscnt = 9'd0;
        end else begin
          m_bscnt = m_bscnt + 9'd1;
        end
      end
      if (sr) begin
        e.d0[8*b +: 8] = SR; e.d1[8*b +: 8] = SR;
        e.k0[b] = 1'b1;      e.k1[b] = 1'b1;
        m_lfsr = SEED;
      end else begin
        ks_next(ks);
        e.d0[8*b +: 8] = dpisk0[b] ? x0 : (x0 ^ ks);
        e.d1[8*b +: 8] = dpisk1[b] ? x1 : (x1 ^ ks);
        e.k0[b] = dpisk0[b];
        e.k1[b] = dpisk1[b];
      end
    end
    if (!twolane) begin
      e.d1 = 16'h0000; e.k1 = 2'b00;
    end
    if (p < 0) e.d0 = 16'h0000;  // p only meaningful in training builds
    sb.push_back(e);
  endtask

  // One clock: drive at negedge, model, sample at the next negedge.
  task automatic cyc(input logic rst, input logic [15:0] d0, input logic [1:0] k0,
                     input logic [15:0] d1, input logic [1:0] k1);
    reset  = rst;
    dpdat0 = d0; dpisk0 = k0;
    dpdat1 = d1; dpisk1 = k1;
    model_push();
    @(posedge dpclk);
    @(negedge dpclk);
    last_exp = sb.pop_front();
    o_d0 = scrdat0; o_k0 = scrisk0;
    o_d1 = scrdat1; o_k1 = scrisk1;
    check("lane0", {14'b0, o_k0, o_d0}, {14'b0, last_exp.k0, last_exp.d0});
    check("lane1", {14'b0, o_k1, o_d1}, {14'b0, last_exp.k1, last_exp.d1});
  endtask

  initial begin
    logic [15:0] r16;
    logic [7:0]  r8;
    @(negedge dpclk);

    // Reset: all outputs zero
    repeat (3) cyc(1'b1, 16'hA5A5, 2'b11, 16'h5A5A, 2'b10);
    check("reset_lane0", {14'b0, o_k0, o_d0}, 32'h0);
    check("reset_lane1", {14'b0, o_k1, o_d1}, 32'h0);

    // First BS after reset becomes SR; zero data then yields the seed keystream
    cyc(1'b0, {8'h00, BS}, 2'b01, {8'h00, BS}, 2'b01);
    check("first_bs_is_sr", {31'b0, o_k0[0]} << 8 | {24'b0, o_d0[7:0]}, {23'b0, 1'b1, SR});
    zq.push_back(o_d0[15:8]);
    repeat (4) begin
      cyc(1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00);
      zq.push_back(o_d0[7:0]);
      zq.push_back(o_d0[15:8]);
    end
    for (int i = 0; i < 8; i++) check("zero_keystream", {24'b0, zq[i]}, {24'b0, zseq[i]});

    // Lane 1 disabled, then lane 1 carrying the same data as lane 0
    twolane = 1'b0;
    repeat (6) begin
      r16 = 16'($urandom);
      cyc(1'b0, r16, 2'b00, 16'hFFFF, 2'b11);
      check("lane1_off", {14'b0, o_k1, o_d1}, 32'h0);
    end
    twolane = 1'b1;
    repeat (6) begin
      r16 = 16'($urandom);
      cyc(1'b0, r16, 2'b00, r16, 2'b00);
      check("lane1_follows_lane0", {16'b0, o_d1}, {16'b0, last_exp.d0});
    end

`ifdef SCRAMBLE_TRAINING_EN
    train = 2'd1;
    repeat (3) begin
      cyc(1'b0, 16'($urandom), 2'b00, 16'($urandom), 2'b00);
      check("tps1", {14'b0, o_k0, o_d0}, {14'b0, 2'b00, 16'h4A4A});
    end
    train = 2'd2;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 16'($urandom), 2'b00, 16'($urandom), 2'b00);
      if (i % 5 < 2) check("tps2", {14'b0, o_k0, o_d0}, {14'b0, 2'b01, 16'hCBBC});
      else           check("tps2", {14'b0, o_k0, o_d0}, {14'b0, 2'b00, 16'h4A4A});
    end
    train = 2'd0;
    cyc(1'b0, 16'h1234, 2'b00, 16'h5678, 2'b00);
    cyc(1'b0, {8'h00, BS}, 2'b01, {8'h00, BS}, 2'b01);
    check("post_train_sr", {24'b0, o_d0[7:0]}, {24'b0, SR});
`else
    // Training disabled: train is ignored and scrambling continues
    train = 2'd2;
    repeat (10) cyc(1'b0, 16'($urandom), 2'b00, 16'($urandom), 2'b00);
    train = 2'd0;
    cyc(1'b0, {8'h00, BS}, 2'b01, {8'h00, BS}, 2'b01);
    check("train_ignored_bs", {24'b0, o_d0[7:0]}, {24'b0, BS});
`endif

    // One-cycle reset mid-stream
    cyc(1'b0, 16'($urandom), 2'b00, 16'($urandom), 2'b00);
    cyc(1'b1, 16'hFFFF, 2'b11, 16'hFFFF, 2'b11);
    check("midreset_lane0", {14'b0, o_k0, o_d0}, 32'h0);
    check("midreset_lane1", {14'b0, o_k1, o_d1}, 32'h0);
    cyc(1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00);
    check("midreset_seed", {16'b0, o_d0}, {16'b0, 16'h17FF});
    // SR in the high byte: low byte still uses the running state (C0)
    cyc(1'b0, {BS, 8'h00}, 2'b10, {BS, 8'h00}, 2'b10);
    check("sr_hi", {24'b0, o_d0[15:8]}, {24'b0, SR});
    check("sr_hi_low_prestate", {24'b0, o_d0[7:0]}, {24'b0, 8'hC0});
    cyc(1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00);
    check("after_sr_hi_seed", {24'b0, o_d0[7:0]}, {24'b0, 8'hFF});

    // Long run: one BS every 20 cycles, SR expected on BS 1 and 513
    cyc(1'b1, 16'h0000, 2'b00, 16'h0000, 2'b00);
    for (int n = 1; n <= 1023; n++) begin
      repeat (19) cyc(1'b0, 16'($urandom), 2'b00, 16'($urandom), 2'b00);
      r8 = 8'($urandom);
      if (n % 2 == 1) begin
        cyc(1'b0, {BS, r8}, 2'b10, {BS, ~r8}, 2'b10);
        check("bs_seq", {24'b0, o_d0[15:8]}, {24'b0, (n == 1 || n == 513) ? SR : BS});
      end else begin
        cyc(1'b0, {r8, BS}, 2'b01, {~r8, BS}, 2'b01);
        check("bs_seq", {24'b0, o_d0[7:0]}, {24'b0, (n == 513) ? SR : BS});
      end
    end
    // BS 1024 (low) passes, BS 1025 (high) in the same cycle is replaced
    cyc(1'b0, {BS, BS}, 2'b11, {BS, BS}, 2'b11);
    check("double_bs", {16'b0, o_d0}, {16'b0, SR, BS});
    cyc(1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00);
    check("double_bs_next_seed", {24'b0, o_d0[7:0]}, {24'b0, 8'hFF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stuff_scramble.md
STUFF_SCRAMBLE -- requirements
Module: scramble

Interface
REQ-001 SHALL have parameter SRPERIOD, default 512: number of BS symbols per emitted SR, counting the SR itself.
REQ-002 SHALL have port dpclk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports dpdat0 and dpdat1, input, 16 bits each: lane 0/1 symbol pair from the stuffing stage; bits [7:0] are sent first, then [15:8].
REQ-005 SHALL have ports dpisk0 and dpisk1, input, 2 bits each: per-byte K flag; bit 0 qualifies [7:0], bit 1 qualifies [15:8].
REQ-006 SHALL have port twolane, input, 1 bit: 1 means lane 1 is active.
REQ-007 SHALL have port train, input, 2 bits: 0 = normal, 1 = TPS1, 2 = TPS2, 3 = same as normal.
REQ-008 SHALL have ports scrdat0 and scrdat1, output, 16 bits each: scrambled symbol pair to the 8b10b encoder.
REQ-009 SHALL have ports scrisk0 and scrisk1, output, 2 bits each: K flags aligned with scrdat0/scrdat1.

Function
REQ-010 SHALL register all outputs, giving exactly one dpclk of latency from input to output.
REQ-011 SHALL use scrambler LFSR G(X)=X^16+X^5+X^4+X^3+1 with seed 16'hFFFF, advancing 8 steps per symbol.
REQ-012 SHALL process the low byte before the high byte within each cycle, so two symbols are handled per clock.
REQ-013 SHALL XOR each data symbol (isk=0) with the 8 LFSR output bits in DisplayPort bit order (bit 0 first).
REQ-014 SHALL pass K symbols (isk=1) unscrambled while still advancing the LFSR.
REQ-015 SHALL scramble lane 1 with the same LFSR state as lane 0, since symbol positions are identical.
REQ-016 SHALL drive scrdat1/scrisk1 to 0 when twolane=0.
REQ-017 SHALL count BS symbols (K with value symBS) on lane 0 with a 9-bit counter bscnt.
REQ-018 SHALL replace a BS with symSR on all active lanes when bscnt==SRPERIOD-1, then set bscnt to 0; any other BS increments bscnt.
REQ-019 SHALL seed the LFSR to 16'hFFFF immediately after an emitted SR, so the next symbol (same cycle high byte, or next cycle low byte) uses the seed.
REQ-020 SHALL, when SR lands in the high byte, scramble the low byte of that cycle with the pre-reset LFSR state.
REQ-021 SHALL handle two BS in one cycle (both bytes) in order, possibly replacing the second one.
REQ-022 SHALL, on the cycle train returns to 0 from a non-zero value, set bscnt=SRPERIOD-1 so that the next BS is emitted as SR.

Reset
REQ-023 SHALL, while reset is high: all outputs 0, LFSR=16'hFFFF, bscnt=SRPERIOD-1, training pointer=0.
REQ-024 SHALL produce, on the first cycle after reset deasserts, outputs derived from that cycle's inputs one clock later; the first BS becomes SR.
REQ-025 SHALL, on reset asserted mid-line, discard any partial state; no symbol from before reset appears after it.

Configuration
REQ-026 SHALL, with macro SCRAMBLE_TRAINING_EN defined, for train=1, output D10.2 (8'h4A, isk=0) on every byte of every active lane, unscrambled, with the LFSR held.
REQ-027 SHALL, with SCRAMBLE_TRAINING_EN defined, for train=2, output the 10-symbol TPS2 cycle K28.5, D11.6, K28.5, D11.6, D10.2 x6 (5 clocks per period) on all active lanes, unscrambled.
REQ-028 SHALL restart the TPS2 pointer at 0 whenever train changes.
REQ-029 SHALL, without SCRAMBLE_TRAINING_EN, keep the train port but ignore it; no training logic is synthesized and REQ-022 never fires.

Structure
REQ-030 SHALL take the symbol constants symBS, symSR, symBE, symK28_5, symD10_2 and symD11_6 from the shared dport.vh include; this block adds symSR and the training symbols there.
REQ-031 SHALL place the per-symbol LFSR step in sub-module scrstep (combinational: 16-bit state in, 8-bit data and isk in, 8-bit data and next state out), instantiated twice in series.

Verification
REQ-032 SHALL be verified by: reset, then all-zero data, isk=0, no BS -> lane-0 bytes FF 17 C0 14 B2 E7 02 82 in time order after the first SR-reseeded point (the SR is forced via a BS at cycle 0).
REQ-033 SHALL be verified by: 1024 BS symbols, one every 20 cycles -> SR emitted on BS number 1 and BS number 513; all other BS pass unchanged.
REQ-034 SHALL be verified by: BS forced as SR in the high byte with data 00 in the next low byte -> SR output, then that low byte equals FF.
REQ-035 SHALL be verified by: twolane=0 with dpdat1=16'hFFFF -> scrdat1=0 and scrisk1=0 throughout; twolane=1 -> scrdat1 follows lane-0 scrambling of the same data.
REQ-036 SHALL be verified, with SCRAMBLE_TRAINING_EN defined, by: train=2 for 10 cycles -> 4A-only pattern absent; the period-5 sequence BC/K, CB, BC/K, CB, 4A x6 repeats twice; then train=0 -> the next BS is SR.
REQ-037 SHALL be verified by: reset pulsed for 1 cycle mid-stream -> outputs 0 during reset; LFSR restarts at FFFF and the first BS afterwards is SR.
